// File: rtl/bar_field_engine.sv
// Scrolling top/bottom bar field, player ride height and collision/HP state machine.
// Sits between the VGA sync generator and the colour mux; all field outputs are pixel-clock registered.
module bar_field_engine #(
    parameter int H_ACTIVE      = 640,
    parameter int BAR_WIDTH     = 40,
    parameter int VISIBLE_WIDTH = 25,
    parameter int NUM_SAMPLES   = 10,
    parameter int AMP_STEP      = 10,
    parameter int FIELD_X0      = 100,
    parameter int FIELD_X1      = 540,
    parameter int FIELD_Y0      = 180,
    parameter int FIELD_Y1      = 400,
    parameter int TOP_DEPTH     = 110,
    parameter int BOT_DEPTH     = 60,
    parameter int PLAYER_X      = 200,
    parameter int PLAYER_BASE_Y = 315,
    parameter int HP_MAX        = 20,
    parameter int HIT_DAMAGE    = 1,
    parameter int IFRAMES       = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_active,
    input  logic       player_pix,
    input  logic       start,
    input  logic [3:0] speed,
    input  logic       direction,
    output logic       bar_pix,
    output logic [9:0] x_offset,
    output logic [9:0] player_y,
    output logic [7:0] hp,
    output logic [1:0] state,
    output logic       flash
);
    localparam int SW     = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int PW     = (BAR_WIDTH > 1) ? $clog2(BAR_WIDTH) : 1;
    localparam int PSEG   = (PLAYER_X / BAR_WIDTH) % NUM_SAMPLES;
    localparam int PPOS   = PLAYER_X % BAR_WIDTH;
    localparam int PDIF   = PSEG - NUM_SAMPLES / 2;
    localparam int PY_RST = PLAYER_BASE_Y - AMP_STEP * ((PDIF < 0) ? -PDIF : PDIF);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PLAY = 2'd1, S_HURT = 2'd2, S_OVER = 2'd3} state_t;

    function automatic logic [11:0] sample_of(input logic [SW-1:0] seg);
        int d;
        d = int'(seg) - NUM_SAMPLES / 2;
        if (d < 0) d = -d;
        return 12'(AMP_STEP * d);
    endfunction

    // Ride height from the column under PLAYER_X for a given offset.
    function automatic logic [9:0] py_of(input logic [SW-1:0] seg, input logic [PW-1:0] pos);
        int c;
        int sg;
        c  = int'(pos) + PPOS;
        sg = int'(seg) + PSEG + ((c >= BAR_WIDTH) ? 1 : 0);
        if (sg >= NUM_SAMPLES) sg -= NUM_SAMPLES;
        return 10'(PLAYER_BASE_Y - int'(sample_of(SW'(sg))));
    endfunction

    state_t          st_q, st_d;
    logic [7:0]      hp_q, hp_d, ifr_q, ifr_d, dmg;
    logic [SW-1:0]   off_seg, seg_d, adv_seg, col_seg, eff_seg, col_seg_nxt;
    logic [PW-1:0]   off_pos, pos_d, adv_pos, col_pos, eff_pos, col_pos_nxt;
    logic [9:0]      py_q, py_d;
    logic            hit_q, hit_d, hit_now, bar_q, pp_q, lit;
    logic [11:0]     s, x12, y12;
    logic            in_x, in_y, top_on, bot_on;

    // Running column counters: reload from the offset at pix_x==0, then step per pixel.
    always_comb begin
        eff_seg     = (pix_x == 10'd0) ? off_seg : col_seg;
        eff_pos     = (pix_x == 10'd0) ? off_pos : col_pos;
        col_pos_nxt = eff_pos + PW'(1);
        col_seg_nxt = eff_seg;
        if (eff_pos == PW'(BAR_WIDTH - 1)) begin
            col_pos_nxt = '0;
            col_seg_nxt = (eff_seg == SW'(NUM_SAMPLES - 1)) ? '0 : eff_seg + SW'(1);
        end
    end

    always_comb begin
        s      = sample_of(eff_seg);
        x12    = {2'b00, pix_x};
        y12    = {2'b00, pix_y};
        in_x   = (x12 > 12'(FIELD_X0)) && (x12 < 12'(FIELD_X1));
        in_y   = (y12 > 12'(FIELD_Y0)) && (y12 < 12'(FIELD_Y1));
        // Limits rearranged as sums so nothing underflows when s is large.
        top_on = (y12 + s) < 12'(FIELD_Y0 + TOP_DEPTH);
        bot_on = (y12 + s + 12'(BOT_DEPTH)) > 12'(FIELD_Y1);
        lit    = video_active && (int'(eff_pos) < VISIBLE_WIDTH) && in_x && in_y && (top_on || bot_on);
    end

    // Offset advanced by one frame step, carry/borrow from pos into seg.
    always_comb begin
        int step_i;
        int ps;
        int ss;
        step_i = (speed == 4'd0) ? 1 : int'(speed);
        ss     = int'(off_seg);
        if (!direction) begin
            ps = int'(off_pos) + step_i;
            if (ps >= BAR_WIDTH) begin
                ps -= BAR_WIDTH;
                ss = (ss == NUM_SAMPLES - 1) ? 0 : ss + 1;
            end
        end else begin
            ps = int'(off_pos) - step_i;
            if (ps < 0) begin
                ps += BAR_WIDTH;
                ss = (ss == 0) ? NUM_SAMPLES - 1 : ss - 1;
            end
        end
        adv_seg = SW'(ss);
        adv_pos = PW'(ps);
    end

    always_comb begin
        st_d    = st_q;
        hp_d    = hp_q;
        ifr_d   = ifr_q;
        seg_d   = off_seg;
        pos_d   = off_pos;
        py_d    = py_q;
        dmg     = (hp_q < 8'(HIT_DAMAGE)) ? hp_q : 8'(HIT_DAMAGE);
        hit_now = pp_q && bar_q && (st_q == S_PLAY);
        hit_d   = frame_tick ? hit_now : (hit_q || hit_now);
        case (st_q)
            S_IDLE: begin
                if (start) begin
                    st_d  = S_PLAY;
                    hit_d = 1'b0;
                end
            end
            S_PLAY: begin
                if (frame_tick) begin
                    seg_d = adv_seg;
                    pos_d = adv_pos;
                    if (hit_q) begin
                        hp_d = hp_q - dmg;
                        if (hp_d == 8'd0) begin
                            st_d = S_OVER;
                        end else begin
                            st_d  = S_HURT;
                            ifr_d = 8'(IFRAMES);
                        end
                    end
                end
            end
            S_HURT: begin
                if (frame_tick) begin
                    seg_d = adv_seg;
                    pos_d = adv_pos;
                    if (ifr_q <= 8'd1) begin
                        ifr_d = '0;
                        st_d  = S_PLAY;
                    end else begin
                        ifr_d = ifr_q - 8'd1;
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    st_d  = S_PLAY;
                    hp_d  = 8'(HP_MAX);
                    seg_d = '0;
                    pos_d = '0;
                    ifr_d = '0;
                    hit_d = 1'b0;
                end
            end
            default: st_d = S_IDLE;
        endcase
        if (frame_tick) py_d = py_of(seg_d, pos_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q    <= S_IDLE;
            hp_q    <= 8'(HP_MAX);
            ifr_q   <= '0;
            off_seg <= '0;
            off_pos <= '0;
            py_q    <= 10'(PY_RST);
            hit_q   <= 1'b0;
            col_seg <= '0;
            col_pos <= '0;
            bar_q   <= 1'b0;
            pp_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            hp_q    <= hp_d;
            ifr_q   <= ifr_d;
            off_seg <= seg_d;
            off_pos <= pos_d;
            py_q    <= py_d;
            hit_q   <= hit_d;
            col_seg <= col_seg_nxt;
            col_pos <= col_pos_nxt;
            bar_q   <= lit;
            pp_q    <= player_pix;
        end
    end

    assign bar_pix  = bar_q;
    assign x_offset = 10'(int'(off_seg) * BAR_WIDTH + int'(off_pos));
    assign player_y = py_q;
    assign hp       = hp_q;
    assign state    = st_q;
    assign flash    = (st_q == S_HURT) && ifr_q[2];
endmodule

// File: tb/tb_bar_field_engine.sv
// Bench for bar_field_engine: a default instance and an HP_MAX=2 instance share one stimulus;
// a per-cycle behavioural model (plain modulo arithmetic on the offset) is checked alongside literal expectations.
module tb_bar_field_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [9:0] pix_x, pix_y;
    logic       video_active, player_pix, start, direction;
    logic [3:0] speed;

    logic [1:0]       bp, fl;
    logic [1:0][9:0]  xo, pyo;
    logic [1:0][7:0]  hpo;
    logic [1:0][1:0]  sto;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    int pp_lo   = -1;
    int pp_hi   = -2;

    int m_state[2], m_hp[2], m_if[2], m_off[2], m_py[2];
    bit m_latch[2], m_bar[2];
    bit m_ppd;
    int m_hpmax[2] = '{20, 2};

    always #5 clk = ~clk;

    bar_field_engine u_dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
        .video_active(video_active), .player_pix(player_pix), .start(start), .speed(speed),
        .direction(direction), .bar_pix(bp[0]), .x_offset(xo[0]), .player_y(pyo[0]),
        .hp(hpo[0]), .state(sto[0]), .flash(fl[0])
    );

    bar_field_engine #(.HP_MAX(2)) u_dut_go (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pix_x(pix_x), .pix_y(pix_y),
        .video_active(video_active), .player_pix(player_pix), .start(start), .speed(speed),
        .direction(direction), .bar_pix(bp[1]), .x_offset(xo[1]), .player_y(pyo[1]),
        .hp(hpo[1]), .state(sto[1]), .flash(fl[1])
    );

    task automatic check(input string nm, input int inst, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, inst, act, exp, $time);
        end
    endtask

    function automatic int samp(input int sg);
        int d;
        d = sg - 5;
        return 10 * ((d < 0) ? -d : d);
    endfunction

    function automatic bit bar_model(input int x, input int y, input bit va, input int off);
        int c, sg, ps, s;
        c  = (x + off) % 400;
        sg = c / 40;
        ps = c % 40;
        s  = samp(sg);
        return va && (ps < 25) && (x > 100) && (x < 540) && (y > 180) && (y < 400) &&
               ((y < 180 + 110 - s) || (y > 400 - s - 60));
    endfunction

    function automatic int py_model(input int off);
        return 315 - samp(((200 + off) % 400) / 40);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_hp[i] = m_hpmax[i]; m_if[i] = 0; m_off[i] = 0;
            m_py[i] = 315; m_latch[i] = 1'b0; m_bar[i] = 1'b0;
        end
        m_ppd = 1'b0;
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int os, stp;
            bit hit, nbar;
            os   = m_state[i];
            hit  = m_ppd && m_bar[i] && (os == 1);
            nbar = bar_model(int'(pix_x), int'(pix_y), video_active, m_off[i]);
            stp  = (speed == 4'd0) ? 1 : int'(speed);
            if (frame_tick && (os == 1 || os == 2))
                m_off[i] = direction ? (m_off[i] + 400 - stp) % 400 : (m_off[i] + stp) % 400;
            if ((os == 0 || os == 3) && start) begin
                m_state[i] = 1;
                if (os == 3) begin
                    m_hp[i] = m_hpmax[i]; m_off[i] = 0; m_if[i] = 0;
                end
            end else if (os == 1 && frame_tick && m_latch[i]) begin
                m_hp[i] = m_hp[i] - ((m_hp[i] < 1) ? m_hp[i] : 1);
                if (m_hp[i] == 0) m_state[i] = 3;
                else begin m_state[i] = 2; m_if[i] = 30; end
            end else if (os == 2 && frame_tick) begin
                m_if[i] = m_if[i] - 1;
                if (m_if[i] <= 0) begin m_if[i] = 0; m_state[i] = 1; end
            end
            if ((os == 0 || os == 3) && start) m_latch[i] = 1'b0;
            else if (frame_tick) m_latch[i] = hit;
            else m_latch[i] = m_latch[i] || hit;
            if (frame_tick) m_py[i] = py_model(m_off[i]);
            m_bar[i] = nbar;
        end
        m_ppd = player_pix;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check("bar_pix", i, int'(bp[i]), int'(m_bar[i]));
                check("x_offset", i, int'(xo[i]), m_off[i]);
                check("player_y", i, int'(pyo[i]), m_py[i]);
                check("hp", i, int'(hpo[i]), m_hp[i]);
                check("state", i, int'(sto[i]), m_state[i]);
                check("flash", i, int'(fl[i]), ((m_state[i] == 2) && (((m_if[i] >> 2) & 1) == 1)) ? 1 : 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic sweep(input int y, input bit va, input int tx, output int got);
        got = -1;
        for (int x = 0; x < 640; x++) begin
            pix_x = 10'(x); pix_y = 10'(y); video_active = va;
            player_pix = (x >= pp_lo) && (x <= pp_hi);
            cyc();
            if (x == tx) got = int'(bp[0]);
        end
        pix_x = '0; pix_y = '0; video_active = 1'b0; player_pix = 1'b0;
        cyc();
    endtask

    initial begin
        int g, snap;
        rst_n = 1'b1; frame_tick = 1'b0; pix_x = '0; pix_y = '0; video_active = 1'b0;
        player_pix = 1'b0; start = 1'b0; speed = '0; direction = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", 0, int'(sto[0]), 0);
        check("rst_hp", 0, int'(hpo[0]), 20);
        check("rst_hp", 1, int'(hpo[1]), 2);
        check("rst_xoff", 0, int'(xo[0]), 0);
        check("rst_py", 0, int'(pyo[0]), 315);
        check("rst_bar", 0, int'(bp[0]), 0);
        check("rst_flash", 0, int'(fl[0]), 0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        chk_on = 1'b1;

        sweep(181, 1'b1, 120, g); check("geo_120_181", 0, g, 1);
        sweep(269, 1'b1, 120, g); check("geo_120_269", 0, g, 1);
        sweep(270, 1'b1, 120, g); check("geo_120_270", 0, g, 0);
        sweep(320, 1'b1, 120, g); check("geo_120_320", 0, g, 0);
        sweep(321, 1'b1, 120, g); check("geo_120_321", 0, g, 1);
        sweep(200, 1'b1, 144, g); check("geo_144_200", 0, g, 1);
        sweep(200, 1'b1, 145, g); check("geo_145_200", 0, g, 0);
        sweep(200, 1'b1, 100, g); check("geo_100_200", 0, g, 0);
        sweep(180, 1'b1, 120, g); check("geo_120_180", 0, g, 0);
        sweep(400, 1'b1, 120, g); check("geo_120_400", 0, g, 0);
        sweep(200, 1'b0, 120, g); check("geo_inactive", 0, g, 0);

        speed = 4'd4;
        tick(); tick();
        check("idle_frozen", 0, int'(xo[0]), 0);
        start = 1'b1; cyc(); start = 1'b0; cyc();
        check("start_play", 0, int'(sto[0]), 1);
        tick(); tick(); tick();
        check("fwd_12", 0, int'(xo[0]), 12);
        speed = 4'd0; tick();
        check("fwd_speed0", 0, int'(xo[0]), 13);
        check("py_fwd", 0, int'(pyo[0]), 315);

        direction = 1'b1; speed = 4'd13; tick();
        check("rev_to0", 0, int'(xo[0]), 0);
        speed = 4'd3; tick();
        check("rev_wrap", 0, int'(xo[0]), 397);
        check("py_rev", 0, int'(pyo[0]), 305);
        direction = 1'b0; speed = 4'd5; tick();
        check("fwd_wrap", 0, int'(xo[0]), 2);
        check("py_fwd_wrap", 0, int'(pyo[0]), 315);

        pp_lo = 101; pp_hi = 539;
        sweep(200, 1'b1, 0, g);
        tick();
        check("hit_hp", 0, int'(hpo[0]), 19);
        check("hit_state", 0, int'(sto[0]), 2);
        check("hit_hp", 1, int'(hpo[1]), 1);
        check("flash_k0", 0, int'(fl[0]), 1);
        sweep(200, 1'b1, 0, g);
        tick();
        check("hurt_immune", 0, int'(hpo[0]), 19);
        for (int k = 2; k <= 30; k++) begin
            tick();
            if (k == 3)  check("flash_k3", 0, int'(fl[0]), 0);
            if (k == 7)  check("flash_k7", 0, int'(fl[0]), 1);
            if (k == 11) check("flash_k11", 0, int'(fl[0]), 0);
            if (k == 29) check("hurt_k29", 0, int'(sto[0]), 2);
        end
        check("iframes_done", 0, int'(sto[0]), 1);
        check("iframes_done", 1, int'(sto[1]), 1);

        sweep(200, 1'b1, 0, g);
        pp_lo = -1; pp_hi = -2;
        tick();
        check("over_hp", 1, int'(hpo[1]), 0);
        check("over_state", 1, int'(sto[1]), 3);
        check("second_hit_hp", 0, int'(hpo[0]), 18);
        snap = m_off[1];
        repeat (5) tick();
        check("over_frozen", 1, int'(xo[1]), snap);
        start = 1'b1; cyc(); start = 1'b0; cyc();
        check("restart_state", 1, int'(sto[1]), 1);
        check("restart_hp", 1, int'(hpo[1]), 2);
        check("restart_xoff", 1, int'(xo[1]), 0);
        check("still_hurt", 0, int'(sto[0]), 2);

        for (int x = 0; x < 130; x++) begin
            pix_x = 10'(x); pix_y = 10'd200; video_active = 1'b1;
            cyc();
        end
        #2;
        chk_on = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_state", 0, int'(sto[0]), 0);
        check("arst_hp", 0, int'(hpo[0]), 20);
        check("arst_xoff", 0, int'(xo[0]), 0);
        check("arst_py", 0, int'(pyo[0]), 315);
        check("arst_bar", 0, int'(bp[0]), 0);
        check("arst_flash", 0, int'(fl[0]), 0);
        pix_x = '0; video_active = 1'b0;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        chk_on = 1'b1;
        repeat (4) cyc();
        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
